data_island_packet_serializer: RTL and testbench

- Consumes one InfoFrame/data-island packet (24-bit header plus four 56-bit subpackets) and emits it over 32 pixel clocks as 9 bits per cycle for the TERC4 data-island encoders.
- Computes BCH parity in flight: 8 parity bits for the header, and 8 parity bits per subpacket.
- Sits directly downstream of the InfoFrame generators and upstream of the TERC4 channel encoders.

---
 rtl/data_island_packet_serializer.sv | 144 ++++++++++++++
 tb/tb_data_island_packet_serializer.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_island_packet_serializer.sv
`default_nettype none
// ============================================================================
// Module   : data_island_packet_serializer
// Brief    : Serialises one data-island packet (24-bit header + 4x56-bit
//            subpackets) into 32 cycles of 9-bit TERC4 lane data, appending
//            BCH parity on the fly. Optional packet counter: DI_PACKET_COUNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module data_island_packet_serializer #(
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clk_pixel,
    input  logic                   reset,
    input  logic                   start,
    input  logic [23:0]            header,
    input  logic [3:0][55:0]       sub,
    output logic                   in_ready,
    output logic                   packet_valid,
    output logic [8:0]             packet_data,
    output logic                   packet_done
`ifdef DI_PACKET_COUNT_EN
    ,
    output logic [COUNT_WIDTH-1:0] packet_count
`endif
);

    localparam logic [4:0] c_last_k   = 5'd31;
    localparam logic [4:0] c_hdr_bits = 5'd24;
    localparam logic [4:0] c_sub_bits = 5'd28;
    localparam logic [7:0] c_bch_poly = 8'h83;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    state_t           r_state;
    logic [4:0]       r_counter;
    logic [23:0]      r_header;
    logic [3:0][55:0] r_sub;
    logic [7:0]       r_hecc;
    logic [3:0][7:0]  r_ecc;

    logic             w_accept;
    logic             w_advance;
    logic [4:0]       w_k;
    logic [23:0]      w_hdr;
    logic [3:0][55:0] w_sub;
    logic [7:0]       w_hecc_in;
    logic [3:0][7:0]  w_ecc_in;
    logic [7:0]       w_hecc_next;
    logic [3:0][7:0]  w_ecc_next;
    logic [8:0]       w_data;

    // COUNT_WIDTH only sizes packet_count; a zero width is never legal.
    if (COUNT_WIDTH < 1) begin : g_count_width_check
        logic w_bad_count_width;
        assign w_bad_count_width = 1'b1;
    end

    function automatic logic [7:0] ecc_step(input logic [7:0] e, input logic d);
        return (e >> 1) ^ ((e[0] ^ d) ? c_bch_poly : 8'h00);
    endfunction

    // Output word for index w_k is formed one cycle early and registered. On
    // accept the word for k=0 is taken straight from the inputs with ECC = 0.
    always_comb begin
        w_accept    = start & in_ready;
        w_advance   = w_accept | ((r_state == ST_SEND) & (r_counter != c_last_k));
        w_k         = w_accept ? 5'd0 : r_counter + 5'd1;
        w_hdr       = w_accept ? header : r_header;
        w_sub       = w_accept ? sub : r_sub;
        w_hecc_in   = w_accept ? 8'h00 : r_hecc;
        w_ecc_in    = w_accept ? '0 : r_ecc;
        w_data      = '0;
        w_hecc_next = w_hecc_in;
        w_ecc_next  = w_ecc_in;

        if (w_k < c_hdr_bits) begin
            w_data[0]   = w_hdr[w_k];
            w_hecc_next = ecc_step(w_hecc_in, w_hdr[w_k]);
        end else begin
            w_data[0]   = w_hecc_in[w_k[2:0]];
        end

        for (int i = 0; i < 4; i++) begin
            if (w_k < c_sub_bits) begin
                w_data[1+i]   = w_sub[i][{w_k, 1'b0}];
                w_data[5+i]   = w_sub[i][{w_k, 1'b1}];
                w_ecc_next[i] = ecc_step(ecc_step(w_ecc_in[i], w_sub[i][{w_k, 1'b0}]),
                                         w_sub[i][{w_k, 1'b1}]);
            end else begin
                w_data[1+i]   = w_ecc_in[i][{w_k[1:0], 1'b0}];
                w_data[5+i]   = w_ecc_in[i][{w_k[1:0], 1'b1}];
            end
        end
    end

    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_counter    <= 5'd0;
            r_header     <= '0;
            r_sub        <= '0;
            r_hecc       <= 8'h00;
            r_ecc        <= '0;
            in_ready     <= 1'b1;
            packet_valid <= 1'b0;
            packet_data  <= 9'd0;
            packet_done  <= 1'b0;
        end else if (w_advance) begin
            if (w_accept) begin
                r_header <= header;
                r_sub    <= sub;
            end
            r_state      <= ST_SEND;
            r_counter    <= w_k;
            r_hecc       <= w_hecc_next;
            r_ecc        <= w_ecc_next;
            packet_valid <= 1'b1;
            packet_data  <= w_data;
            packet_done  <= (w_k == c_last_k);
            in_ready     <= (w_k == c_last_k);
        end else begin
            r_state      <= ST_IDLE;
            packet_valid <= 1'b0;
            packet_data  <= 9'd0;
            packet_done  <= 1'b0;
            in_ready     <= 1'b1;
        end
    end

`ifdef DI_PACKET_COUNT_EN
    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            packet_count <= '0;
        end else if (packet_done && (packet_count != {COUNT_WIDTH{1'b1}})) begin
            packet_count <= packet_count + 1'b1;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_data_island_packet_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_island_packet_serializer
// Brief    : Directed self-checking bench for data_island_packet_serializer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_data_island_packet_serializer;

    logic             clk_pixel = 1'b0;
    logic             reset     = 1'b1;
    logic             start     = 1'b0;
    logic [23:0]      header    = '0;
    logic [3:0][55:0] sub       = '0;
    logic             in_ready;
    logic             packet_valid;
    logic [8:0]       packet_data;
    logic             packet_done;
`ifdef DI_PACKET_COUNT_EN
    logic [15:0]      packet_count;
    int               exp_count = 0;
`endif

    int         errors = 0;
    int         checks = 0;
    logic [8:0] exp_data [32];

    data_island_packet_serializer #(.COUNT_WIDTH(16)) dut (
        .clk_pixel    (clk_pixel),
        .reset        (reset),
        .start        (start),
        .header       (header),
        .sub          (sub),
        .in_ready     (in_ready),
        .packet_valid (packet_valid),
        .packet_data  (packet_data),
        .packet_done  (packet_done)
`ifdef DI_PACKET_COUNT_EN
        ,
        .packet_count (packet_count)
`endif
    );

    always #5 clk_pixel = ~clk_pixel;

    task automatic tick();
        @(posedge clk_pixel);
        #1;
    endtask

    function automatic logic [7:0] bch(input logic [7:0] e, input logic d);
        return (e >> 1) ^ ((e[0] ^ d) ? 8'h83 : 8'h00);
    endfunction

    // Golden model: build each full codeword (data then parity) bit-serially,
    // then slice it into the 32 lane words.
    task automatic build_expect(input logic [23:0] h, input logic [3:0][55:0] s);
        logic [7:0]  e;
        logic [31:0] hcw;
        logic [63:0] scw;
        e = 8'h00;
        for (int b = 0; b < 24; b++) e = bch(e, h[b]);
        hcw = {e, h};
        for (int k = 0; k < 32; k++) exp_data[k] = {8'd0, hcw[k]};
        for (int i = 0; i < 4; i++) begin
            e = 8'h00;
            for (int b = 0; b < 56; b++) e = bch(e, s[i][b]);
            scw = {e, s[i]};
            for (int k = 0; k < 32; k++) begin
                exp_data[k][1+i] = scw[2*k];
                exp_data[k][5+i] = scw[2*k+1];
            end
        end
    endtask

    task automatic launch(input logic [23:0] h, input logic [3:0][55:0] s);
        header = h;
        sub    = s;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        header = ~h;
        sub    = ~s;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        checks += 4;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
        if (packet_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b want=0", packet_valid); end
        if (packet_data !== 9'd0) begin errors++; $display("FAIL reset_data got=%h want=000", packet_data); end
        if (packet_done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b want=0", packet_done); end
`ifdef DI_PACKET_COUNT_EN
        checks++;
        if (packet_count !== 16'd0) begin errors++; $display("FAIL reset_count got=%0d want=0", packet_count); end
`endif
    endtask

    task automatic test_all_zero();
        launch(24'h0, '0);
        for (int k = 0; k < 32; k++) begin
            checks += 4;
            if (packet_valid !== 1'b1) begin errors++; $display("FAIL zero_valid k=%0d got=%b want=1", k, packet_valid); end
            if (packet_data !== 9'd0) begin errors++; $display("FAIL zero_data k=%0d got=%h want=000", k, packet_data); end
            if (packet_done !== (k == 31)) begin errors++; $display("FAIL zero_done k=%0d got=%b want=%b", k, packet_done, k == 31); end
            if (in_ready !== (k == 31)) begin errors++; $display("FAIL zero_in_ready k=%0d got=%b want=%b", k, in_ready, k == 31); end
            tick();
        end
        checks += 2;
        if (packet_valid !== 1'b0) begin errors++; $display("FAIL zero_end_valid got=%b want=0", packet_valid); end
        if (in_ready !== 1'b1) begin errors++; $display("FAIL zero_end_in_ready got=%b want=1", in_ready); end
`ifdef DI_PACKET_COUNT_EN
        exp_count++;
        checks++;
        if (packet_count !== 16'(exp_count)) begin errors++; $display("FAIL zero_count got=%0d want=%0d", packet_count, exp_count); end
`endif
    endtask

    task automatic test_header_parity();
        logic [31:0] b0;
        b0 = 32'h8380_0000;
        launch(24'h800000, '0);
        for (int k = 0; k < 32; k++) begin
            checks++;
            if (packet_data !== {8'd0, b0[k]}) begin
                errors++;
                $display("FAIL hdr_parity k=%0d got=%h want=%h", k, packet_data, {8'd0, b0[k]});
            end
            tick();
        end
`ifdef DI_PACKET_COUNT_EN
        exp_count++;
`endif
    endtask

    task automatic test_sub_parity();
        logic [3:0][55:0] s;
        logic [31:0]      ev;
        logic [31:0]      od;
        s    = '0;
        s[2] = 56'h80_0000_0000_0000;
        ev   = 32'h1000_0000;
        od   = 32'h9800_0000;
        launch(24'h0, s);
        for (int k = 0; k < 32; k++) begin
            checks++;
            if (packet_data !== {1'b0, od[k], 3'b000, ev[k], 3'b000}) begin
                errors++;
                $display("FAIL sub_parity k=%0d got=%h want=%h", k, packet_data,
                         {1'b0, od[k], 3'b000, ev[k], 3'b000});
            end
            tick();
        end
`ifdef DI_PACKET_COUNT_EN
        exp_count++;
`endif
    endtask

    task automatic test_back_to_back();
        logic [23:0]      ha;
        logic [23:0]      hb;
        logic [3:0][55:0] sa;
        logic [3:0][55:0] sb;
        ha = 24'hA5_3C_96;
        sa = {56'h0123_4567_89AB_CD, 56'hFEDC_BA98_7654_32, 56'h00FF_00FF_00FF_00, 56'h8000_0000_0000_01};
        hb = 24'h1F_2E_3D;
        sb = {56'hDEAD_BEEF_CAFE_42, 56'h0000_0000_0000_00, 56'h5555_5555_5555_55, 56'hAAAA_AAAA_AAAA_AA};
        build_expect(ha, sa);
        header = ha;
        sub    = sa;
        start  = 1'b1;
        tick();
        header = hb;
        sub    = sb;
        for (int n = 0; n < 64; n++) begin
            if (n == 32) build_expect(hb, sb);
            if (n == 63) start = 1'b0;
            checks += 3;
            if (packet_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid n=%0d got=%b want=1", n, packet_valid); end
            if (packet_done !== ((n % 32) == 31)) begin errors++; $display("FAIL b2b_done n=%0d got=%b want=%b", n, packet_done, (n % 32) == 31); end
            if (packet_data !== exp_data[n % 32]) begin errors++; $display("FAIL b2b_data n=%0d got=%h want=%h", n, packet_data, exp_data[n % 32]); end
            if (n == 33) begin
                header = ~hb;
                sub    = ~sb;
            end
            tick();
        end
        checks++;
        if (packet_valid !== 1'b0) begin errors++; $display("FAIL b2b_end_valid got=%b want=0", packet_valid); end
`ifdef DI_PACKET_COUNT_EN
        exp_count += 2;
        checks++;
        if (packet_count !== 16'(exp_count)) begin errors++; $display("FAIL b2b_count got=%0d want=%0d", packet_count, exp_count); end
`endif
    endtask

    task automatic test_reset_mid();
        launch(24'hFFFFFF, {4{56'hFF_FFFF_FFFF_FFFF}});
        repeat (10) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks += 4;
        if (packet_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid got=%b want=0", packet_valid); end
        if (packet_data !== 9'd0) begin errors++; $display("FAIL rmid_data got=%h want=000", packet_data); end
        if (in_ready !== 1'b1) begin errors++; $display("FAIL rmid_in_ready got=%b want=1", in_ready); end
        if (packet_done !== 1'b0) begin errors++; $display("FAIL rmid_done got=%b want=0", packet_done); end
        for (int n = 0; n < 24; n++) begin
            checks++;
            if (packet_valid !== 1'b0 || packet_done !== 1'b0) begin
                errors++;
                $display("FAIL rmid_idle n=%0d got=%b%b want=00", n, packet_valid, packet_done);
            end
            tick();
        end
`ifdef DI_PACKET_COUNT_EN
        exp_count = 0;
        checks++;
        if (packet_count !== 16'd0) begin errors++; $display("FAIL rmid_count got=%0d want=0", packet_count); end
`endif
    endtask

    task automatic test_ignored_start();
        logic [23:0]      h;
        logic [3:0][55:0] s;
        h = 24'h0C_0F_FE;
        s = {56'h1111_2222_3333_44, 56'h5555_6666_7777_88, 56'h9999_AAAA_BBBB_CC, 56'hDDDD_EEEE_FFFF_00};
        build_expect(h, s);
        launch(h, s);
        for (int k = 0; k < 32; k++) begin
            start = (k == 5);
            checks++;
            if (packet_data !== exp_data[k]) begin
                errors++;
                $display("FAIL ign_data k=%0d got=%h want=%h", k, packet_data, exp_data[k]);
            end
            tick();
        end
        start = 1'b0;
        for (int n = 0; n < 3; n++) begin
            checks++;
            if (packet_valid !== 1'b0) begin errors++; $display("FAIL ign_idle n=%0d got=%b want=0", n, packet_valid); end
            tick();
        end
`ifdef DI_PACKET_COUNT_EN
        exp_count++;
        checks++;
        if (packet_count !== 16'(exp_count)) begin errors++; $display("FAIL ign_count got=%0d want=%0d", packet_count, exp_count); end
`endif
    endtask

    initial begin
        test_reset();
        test_all_zero();
        test_header_parity();
        test_sub_parity();
        test_back_to_back();
        test_reset_mid();
        test_ignored_start();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
